bcd_converter: RTL and testbench

//   Converts a 9-bit unsigned binary value (0..511) to three packed BCD digits
//   (hundreds, tens, ones) for the hex/decimal value display path.

---
 rtl/bcd_converter.sv | 56 +++++
 tb/tb_bcd_converter.sv | 119 +++++++++++
 2 files changed

// File: rtl/bcd_converter.sv
// Binary to BCD converter for the decimal value display path.
// A 9-bit unsigned value (0..511) is converted with combinational shift-add-3
// (double-dabble) logic. The three BCD digits are registered once, so the
// digits follow a stable input after exactly one clock.
module bcd_converter (
    input  logic       clk,
    input  logic       reset,
    input  logic [8:0] value,
    output logic [3:0] hund,
    output logic [3:0] tens,
    output logic [3:0] ones
);

    localparam int unsigned InWidth  = 9;
    localparam int unsigned BcdWidth = 12;

    // Correct one BCD nibble ahead of a shift: codes 5..9 would overflow past 9
    // when doubled, so add 3 to make the carry land in the next digit.
    function automatic logic [3:0] add3(input logic [3:0] nib);
        return (nib >= 4'd5) ? (nib + 4'd3) : nib;
    endfunction

    logic [BcdWidth-1:0] scratch;
    logic [3:0]          hund_d;
    logic [3:0]          tens_d;
    logic [3:0]          ones_d;

    // Double-dabble core: nine correct-then-shift rounds, MSB of value first.
    // The correction only precedes each shift, so nothing is added after the last.
    always_comb begin
        scratch = '0;
        for (int i = InWidth - 1; i >= 0; i--) begin
            scratch[11:8] = add3(scratch[11:8]);
            scratch[7:4]  = add3(scratch[7:4]);
            scratch[3:0]  = add3(scratch[3:0]);
            scratch       = {scratch[BcdWidth-2:0], value[i]};
        end
        hund_d = scratch[11:8];
        tens_d = scratch[7:4];
        ones_d = scratch[3:0];
    end

    // Output digit registers; synchronous reset wins over a load.
    always_ff @(posedge clk) begin
        if (reset) begin
            hund <= 4'd0;
            tens <= 4'd0;
            ones <= 4'd0;
        end else begin
            hund <= hund_d;
            tens <= tens_d;
            ones <= ones_d;
        end
    end

endmodule

// File: tb/tb_bcd_converter.sv
// Self-checking bench for bcd_converter: directed vector table, latency and
// reset sequences, and a full 0..511 sweep against an arithmetic reference.
module tb_bcd_converter;

    logic       clk;
    logic       reset;
    logic [8:0] value;
    logic [3:0] hund;
    logic [3:0] tens;
    logic [3:0] ones;

    int checks;
    int fails;

    bcd_converter dut (
        .clk   (clk),
        .reset (reset),
        .value (value),
        .hund  (hund),
        .tens  (tens),
        .ones  (ones)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [8:0] v;
        logic [3:0] h;
        logic [3:0] t;
        logic [3:0] o;
    } vec_t;

    vec_t vecs [12];

    task automatic check_digits(input string name, input logic [3:0] eh,
                                input logic [3:0] et, input logic [3:0] eo);
        checks++;
        if (hund !== eh || tens !== et || ones !== eo) begin
            fails++;
            $display("FAIL %s: got %0d/%0d/%0d, expected %0d/%0d/%0d",
                     name, hund, tens, ones, eh, et, eo);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    initial begin
        checks = 0;
        fails  = 0;

        vecs[0]  = '{9'd0,   4'd0, 4'd0, 4'd0};
        vecs[1]  = '{9'd511, 4'd5, 4'd1, 4'd1};
        vecs[2]  = '{9'd255, 4'd2, 4'd5, 4'd5};
        vecs[3]  = '{9'd9,   4'd0, 4'd0, 4'd9};
        vecs[4]  = '{9'd10,  4'd0, 4'd1, 4'd0};
        vecs[5]  = '{9'd99,  4'd0, 4'd9, 4'd9};
        vecs[6]  = '{9'd100, 4'd1, 4'd0, 4'd0};
        vecs[7]  = '{9'd199, 4'd1, 4'd9, 4'd9};
        vecs[8]  = '{9'd200, 4'd2, 4'd0, 4'd0};
        vecs[9]  = '{9'd345, 4'd3, 4'd4, 4'd5};
        vecs[10] = '{9'd87,  4'd0, 4'd8, 4'd7};
        vecs[11] = '{9'd490, 4'd4, 4'd9, 4'd0};

        // Reset held for two edges with a live value on the input.
        reset = 1'b1;
        value = 9'd345;
        step();
        step();
        check_digits("reset_hold", 4'd0, 4'd0, 4'd0);
        reset = 1'b0;
        step();
        check_digits("reset_release", 4'd3, 4'd4, 4'd5);

        // Directed table.
        for (int i = 0; i < 12; i++) begin
            value = vecs[i].v;
            step();
            check_digits($sformatf("vec_%0d", vecs[i].v), vecs[i].h, vecs[i].t, vecs[i].o);
        end

        // Latency: a mid-cycle input change is invisible until the next edge.
        value = 9'd123;
        step();
        check_digits("lat_123", 4'd1, 4'd2, 4'd3);
        value = 9'd456;
        #2;
        check_digits("lat_hold", 4'd1, 4'd2, 4'd3);
        step();
        check_digits("lat_456", 4'd4, 4'd5, 4'd6);

        // Exhaustive sweep with a reset pulse at value 300.
        for (int v = 0; v < 512; v++) begin
            int sum;
            value = 9'(v);
            if (v == 300) reset = 1'b1;
            step();
            if (v == 300) begin
                check_digits("sweep_reset", 4'd0, 4'd0, 4'd0);
                reset = 1'b0;
            end else begin
                sum = 100 * int'(hund) + 10 * int'(tens) + int'(ones);
                checks++;
                if (sum != v || tens > 4'd9 || ones > 4'd9 || hund > 4'd5) begin
                    fails++;
                    $display("FAIL sweep_%0d: got %0d/%0d/%0d, expected %0d/%0d/%0d",
                             v, hund, tens, ones, v / 100, (v / 10) % 10, v % 10);
                end
            end
        end

        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end

endmodule
